// File: rtl/arb_pkg.sv
// Shared constants for the 8-way round-robin arbiter.
// Requester count, index width and FSM state encodings.
package arb_pkg;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

endpackage

// File: rtl/rr_prio_enc8.sv
// Rotating-priority 8-to-3 encoder.
// Rotates req by ptr, picks the lowest set bit, then rotates the index back.
module rr_prio_enc8
    import arb_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N-1:0]     rot;
    logic [IDX_W-1:0] pos;

    // Rotate right by ptr so the current priority holder lands on bit 0
    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[IDX_W'(i) + ptr];
        end
    end

    // Fixed LSB-first priority encode of the rotated vector
    always_comb begin
        pos = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos = IDX_W'(i);
            end
        end
    end

    // Undo the rotation; the 3-bit add wraps modulo 8
    assign idx = pos + ptr;
    assign any = |req;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with registered, held grants.
// A grant is held until its request drops, en drops, or MAX_HOLD expires.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD - 1);

    logic [0:0]       state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [IDX_W-1:0] win;
    logic             any;

    rr_prio_enc8 u_enc (
        .req (req),
        .ptr (ptr),
        .idx (win),
        .any (any)
    );

    // Grant FSM: arbitrate in IDLE, hold or release in GRANT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_idx  <= '0;
            gnt_vld  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && any) begin
                        gnt      <= N'(1) << win;
                        gnt_idx  <= win;
                        gnt_vld  <= 1'b1;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (!en) begin
                        // Disable is not a release: priority stays put
                        gnt     <= '0;
                        gnt_vld <= 1'b0;
                        state   <= IDLE;
                    end else if (!req[gnt_idx]) begin
                        gnt     <= '0;
                        gnt_vld <= 1'b0;
                        ptr     <= gnt_idx + IDX_W'(1);
                        state   <= IDLE;
                    end else if (hold_cnt == LAST) begin
                        gnt     <= '0;
                        gnt_vld <= 1'b0;
                        ptr     <= gnt_idx + IDX_W'(1);
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8.
// Each task drives one scenario and checks {gnt,gnt_idx,gnt_vld,timeout}.
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    int vectors = 0;
    int miscompares = 0;

    rr_arbiter8 dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        req = 8'h00;
        tick();
        vectors++;
        if ({gnt, gnt_idx, gnt_vld, timeout} !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_hold: got gnt=%h idx=%0d vld=%b to=%b want all 0",
                     gnt, gnt_idx, gnt_vld, timeout);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if ({gnt, gnt_vld, timeout} !== 10'h0) begin
                miscompares++;
                $display("FAIL idle_no_req[%0d]: got gnt=%h vld=%b to=%b want 0",
                         i, gnt, gnt_vld, timeout);
            end
        end
    endtask

    task automatic test_basic();
        req = 8'h24;
        tick();
        vectors++;
        if ({gnt, gnt_idx, gnt_vld} !== {8'h04, 3'd2, 1'b1}) begin
            miscompares++;
            $display("FAIL basic_grant: got gnt=%h idx=%0d vld=%b want 04/2/1",
                     gnt, gnt_idx, gnt_vld);
        end
        req = 8'h20;
        tick();
        vectors++;
        if ({gnt, gnt_idx, gnt_vld, timeout} !== {8'h00, 3'd2, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL basic_release: got gnt=%h idx=%0d vld=%b to=%b want 00/2/0/0",
                     gnt, gnt_idx, gnt_vld, timeout);
        end
        tick();
        vectors++;
        if ({gnt, gnt_idx, gnt_vld} !== {8'h20, 3'd5, 1'b1}) begin
            miscompares++;
            $display("FAIL basic_next: got gnt=%h idx=%0d vld=%b want 20/5/1",
                     gnt, gnt_idx, gnt_vld);
        end
        req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_fairness();
        logic [7:0] one;
        logic [2:0] e;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        req = 8'hFF;
        tick();
        for (int k = 0; k < 9; k++) begin
            e   = 3'(k);
            one = 8'h01 << e;
            vectors++;
            if ({gnt, gnt_idx, gnt_vld} !== {one, e, 1'b1}) begin
                miscompares++;
                $display("FAIL fair_grant[%0d]: got gnt=%h idx=%0d vld=%b want %h/%0d/1",
                         k, gnt, gnt_idx, gnt_vld, one, e);
            end
            req = 8'hFF & ~one;
            tick();
            vectors++;
            if ({gnt, gnt_vld} !== 9'h0) begin
                miscompares++;
                $display("FAIL fair_bubble[%0d]: got gnt=%h vld=%b want 0",
                         k, gnt, gnt_vld);
            end
            if (k < 8) begin
                req = 8'hFF;
                tick();
            end
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_timeout();
        req = 8'h80;
        for (int c = 0; c < 16; c++) begin
            tick();
            vectors++;
            if ({gnt, gnt_idx, gnt_vld, timeout} !== {8'h80, 3'd7, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL hold[%0d]: got gnt=%h idx=%0d vld=%b to=%b want 80/7/1/0",
                         c, gnt, gnt_idx, gnt_vld, timeout);
            end
        end
        tick();
        vectors++;
        if ({gnt, gnt_vld, timeout} !== {8'h00, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL forced_release: got gnt=%h vld=%b to=%b want 00/0/1",
                     gnt, gnt_vld, timeout);
        end
        tick();
        vectors++;
        if ({gnt, gnt_idx, gnt_vld, timeout} !== {8'h80, 3'd7, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL regrant: got gnt=%h idx=%0d vld=%b to=%b want 80/7/1/0",
                     gnt, gnt_idx, gnt_vld, timeout);
        end
        req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_en_drop();
        req = 8'h18;
        tick();
        vectors++;
        if ({gnt, gnt_idx, gnt_vld} !== {8'h08, 3'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL en_grant: got gnt=%h idx=%0d vld=%b want 08/3/1",
                     gnt, gnt_idx, gnt_vld);
        end
        en = 1'b0;
        tick();
        vectors++;
        if ({gnt, gnt_vld, timeout} !== 10'h0) begin
            miscompares++;
            $display("FAIL en_drop: got gnt=%h vld=%b to=%b want 0/0/0",
                     gnt, gnt_vld, timeout);
        end
        tick();
        vectors++;
        if ({gnt, gnt_vld} !== 9'h0) begin
            miscompares++;
            $display("FAIL en_low_idle: got gnt=%h vld=%b want 0", gnt, gnt_vld);
        end
        en = 1'b1;
        tick();
        vectors++;
        if ({gnt, gnt_idx, gnt_vld} !== {8'h08, 3'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL en_regrant: got gnt=%h idx=%0d vld=%b want 08/3/1",
                     gnt, gnt_idx, gnt_vld);
        end
        req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        req = 8'h81;
        tick();
        vectors++;
        if ({gnt, gnt_idx, gnt_vld} !== {8'h80, 3'd7, 1'b1}) begin
            miscompares++;
            $display("FAIL pre_rst_grant: got gnt=%h idx=%0d vld=%b want 80/7/1",
                     gnt, gnt_idx, gnt_vld);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({gnt, gnt_idx, gnt_vld, timeout} !== 13'h0) begin
            miscompares++;
            $display("FAIL async_rst: got gnt=%h idx=%0d vld=%b to=%b want all 0",
                     gnt, gnt_idx, gnt_vld, timeout);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if ({gnt, gnt_idx, gnt_vld} !== {8'h01, 3'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL post_rst_grant: got gnt=%h idx=%0d vld=%b want 01/0/1",
                     gnt, gnt_idx, gnt_vld);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fairness();
        test_timeout();
        test_en_drop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
